// File: rtl/tohost_pkg.sv
// Shared constants for the tohost mailbox monitor: FSM encodings and
// the device/command tag that marks a console write.
package tohost_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] CON_DEV  = 8'h01;
    localparam logic [7:0] CON_CMD  = 8'h01;

    localparam int EXIT_BIT = 0;

    // hi = data[63:48]
    function automatic logic is_console(input logic [15:0] hi);
        return hi == {CON_DEV, CON_CMD};
    endfunction

endpackage

// File: rtl/tohost_monitor_if.sv
// Write-snoop and console-stream signals between the DUT side (master)
// and the tohost monitor (slave).
interface tohost_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              con_valid;
    logic              con_ready;
    logic [7:0]        con_data;

    modport master (
        output wr_valid, wr_addr, wr_data, con_ready,
        input  wr_ready, con_valid, con_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, con_ready,
        output wr_ready, con_valid, con_data
    );
endinterface

// File: rtl/tohost_con_fifo.sv
// Small synchronous console FIFO; head entry is read straight from the
// storage registers so a push is visible on the output one edge later.
module tohost_con_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [AW:0]             r_wptr;
    logic [AW:0]             r_rptr;
    logic                    w_do_push;
    logic                    w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot in the same cycle, so push is allowed when full.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_din;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_do_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// Snoops DUT writes to the tohost mailbox, streams console characters and
// reports a sticky done/pass/hang verdict with a cycle count.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter int                ADDR_W           = 32,
    parameter int                DATA_W           = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR      = ADDR_W'(32'h8000_1000),
    parameter int                CON_DEPTH        = 4,
    parameter int unsigned       HEARTBEAT_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    tohost_monitor_if.slave bus,
    output logic        done,
    output logic        pass,
    output logic        hang,
    output logic [30:0] exit_code,
    output logic [63:0] cycles
);
    localparam int WD_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(HEARTBEAT_CYCLES);

    logic [1:0]      r_state;
    logic [WD_W-1:0] r_wdog;
    logic [30:0]     r_exit_code;
    logic            r_hang;
    logic            r_pass;
    logic [63:0]     r_cycles;

    logic        w_acc;
    logic        w_hit;
    logic        w_con;
    logic        w_push;
    logic        w_exit;
    logic [30:0] w_code;
    logic        w_expire;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;

    assign w_acc  = bus.wr_valid && bus.wr_ready;
    assign w_hit  = w_acc && (r_state == ST_RUN) && (bus.wr_addr == TOHOST_ADDR)
                    && (bus.wr_data != '0);
    // Console tag is checked before the exit bit: odd characters set data[0].
    assign w_con  = is_console(bus.wr_data[63:48]);
    assign w_push = w_hit && w_con;
    assign w_exit = w_hit && !w_con;
    assign w_code = bus.wr_data[EXIT_BIT] ? bus.wr_data[EXIT_BIT+31:EXIT_BIT+1] : '1;

    // An accepted write in the expiry cycle keeps the test alive.
    assign w_expire = (HEARTBEAT_CYCLES != 0) && (r_state == ST_RUN)
                      && (r_wdog == WD_MAX) && !w_acc;

    assign w_pop         = !w_empty && bus.con_ready;
    assign bus.con_valid = !w_empty;
    assign bus.wr_ready  = (r_state == ST_RUN) ? (!w_full || w_pop) : 1'b1;

    tohost_con_fifo #(
        .DEPTH (CON_DEPTH),
        .W     (8)
    ) u_con_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (bus.wr_data[7:0]),
        .i_pop   (w_pop),
        .o_dout  (bus.con_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_wdog      <= '0;
            r_exit_code <= '0;
            r_hang      <= 1'b0;
            r_pass      <= 1'b0;
            r_cycles    <= '0;
        end else begin
            if ((r_state != ST_DONE) && (r_cycles != '1))
                r_cycles <= r_cycles + 64'd1;

            case (r_state)
                ST_RUN: begin
                    if (w_acc)
                        r_wdog <= '0;
                    else if (r_wdog != WD_MAX)
                        r_wdog <= r_wdog + WD_W'(1);

                    if (w_exit) begin
                        r_state     <= ST_DRAIN;
                        r_exit_code <= w_code;
                        r_pass      <= (w_code == '0);
                    end else if (w_expire) begin
                        r_state <= ST_DRAIN;
                        r_hang  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty)
                        r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign hang      = r_hang;
    assign exit_code = r_exit_code;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed and randomized checks of tohost_monitor against a queue-based
// model of the mailbox protocol.
module tb_tohost_monitor;
    localparam logic [31:0] TH    = 32'h8000_1000;
    localparam int          DEPTH = 4;
    localparam int          HB    = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        done;
    logic        pass;
    logic        hang;
    logic [30:0] exit_code;
    logic [63:0] cycles;

    int n_checks = 0;
    int n_err    = 0;

    tohost_monitor_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    tohost_monitor #(
        .ADDR_W           (32),
        .DATA_W           (64),
        .TOHOST_ADDR      (TH),
        .CON_DEPTH        (DEPTH),
        .HEARTBEAT_CYCLES (HB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .done      (done),
        .pass      (pass),
        .hang      (hang),
        .exit_code (exit_code),
        .cycles    (cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.con_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Presents a write and holds it until accepted or the budget runs out.
    task automatic wr(input logic [31:0] a, input logic [63:0] d, input int budget);
        bit ok;
        ok           = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        for (int i = 0; i < budget && !ok; i++) begin
            #2;
            ok = bus.wr_ready;
            @(posedge clock);
            #1;
        end
        bus.wr_valid = 1'b0;
        chk("wr_accept", {63'd0, ok}, 64'd1);
    endtask

    function automatic logic [63:0] con_w(input logic [7:0] ch);
        return {16'h0101, 40'h0, ch};
    endfunction

    logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    logic [7:0] ch;
    bit         exited;
    bit         exit_sent;
    bit         pend;
    bit         exp_rdy;
    bit         acc;
    int         k;

    initial begin
        // reset values
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.con_ready = 1'b0;
        #1;
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_con_valid", bus.con_valid, 0);
        chk("rst_con_data", bus.con_data, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_hang", hang, 0);
        chk("rst_exit_code", exit_code, 0);
        chk("rst_cycles", cycles, 0);

        // pass exit: DRAIN after the write edge, DONE one edge later
        do_reset();
        wr(TH, 64'h1, 2);
        chk("pass_done_early", done, 0);
        step();
        chk("pass_done", done, 1);
        chk("pass_pass", pass, 1);
        chk("pass_exit_code", exit_code, 0);
        chk("pass_hang", hang, 0);
        chk("pass_cycles", cycles, 2);
        repeat (3) step();
        chk("pass_cycles_frozen", cycles, 2);

        // fail exit, then a write in DONE is swallowed
        do_reset();
        wr(TH, 64'h7, 2);
        step();
        chk("fail_done", done, 1);
        chk("fail_exit_code", exit_code, 3);
        chk("fail_pass", pass, 0);
        wr(TH, 64'h1, 1);
        step();
        chk("fail_exit_code_held", exit_code, 3);
        chk("fail_pass_held", pass, 0);
        chk("fail_done_held", done, 1);

        // console with backpressure
        do_reset();
        for (int i = 0; i < 4; i++) wr(TH, con_w(hello[i]), 2);
        chk("con_full_wr_ready", bus.wr_ready, 0);
        chk("con_valid_full", bus.con_valid, 1);
        chk("con_head", bus.con_data, 8'h48);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = TH;
        bus.wr_data  = con_w(hello[4]);
        step();
        step();
        chk("con_held_wr_ready", bus.wr_ready, 0);
        chk("con_head_held", bus.con_data, 8'h48);
        got.delete();
        fork
            begin
                wr(TH, con_w(hello[4]), 10);
                wr(TH, 64'h1, 10);
            end
            begin
                bus.con_ready = 1'b1;
                for (int c = 0; c < 40; c++) begin
                    #2;
                    if (bus.con_valid && bus.con_ready) got.push_back(bus.con_data);
                    if (done) begin
                        chk("con_done_after_last", got.size(), 5);
                        break;
                    end
                    @(posedge clock);
                    #1;
                end
            end
        join
        chk("con_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("con_char", got[i], hello[i]);
        chk("con_done", done, 1);
        chk("con_pass", pass, 1);

        // watchdog expiry: count reaches HB, DRAIN, then DONE
        do_reset();
        repeat (HB + 1) step();
        chk("wd_done_early", done, 0);
        step();
        chk("wd_done", done, 1);
        chk("wd_hang", hang, 1);
        chk("wd_pass", pass, 0);
        chk("wd_exit_code", exit_code, 0);
        chk("wd_cycles", cycles, HB + 2);

        // write in the expiry cycle wins
        do_reset();
        repeat (HB) step();
        chk("wd_edge_done_early", done, 0);
        wr(TH + 32'd8, 64'h5, 1);
        step();
        step();
        chk("wd_edge_done", done, 0);
        chk("wd_edge_hang", hang, 0);

        // ignored writes and protocol error
        do_reset();
        wr(TH, 64'h0, 2);
        wr(TH + 32'd4, 64'h1, 2);
        step();
        chk("ign_done", done, 0);
        chk("ign_exit_code", exit_code, 0);
        wr(TH, 64'h0200_0000_0000_0000, 2);
        step();
        chk("err_done", done, 1);
        chk("err_exit_code", exit_code, 31'h7FFF_FFFF);
        chk("err_pass", pass, 0);
        chk("err_hang", hang, 0);

        // asynchronous reset while draining
        do_reset();
        wr(TH, con_w(8'h41), 2);
        wr(TH, con_w(8'h42), 2);
        wr(TH, 64'h1, 2);
        step();
        chk("mid_done_pre", done, 0);
        chk("mid_valid_pre", bus.con_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_con_valid", bus.con_valid, 0);
        chk("mid_con_data", bus.con_data, 0);
        chk("mid_done", done, 0);
        chk("mid_cycles", cycles, 0);
        @(posedge clock);
        #1;
        reset         = 1'b0;
        bus.con_ready = 1'b0;
        wr(TH, 64'h1, 2);
        step();
        chk("mid_after_done", done, 1);
        chk("mid_after_pass", pass, 1);

        // randomized traffic against the queue model
        do_reset();
        exp_q.delete();
        exited    = 1'b0;
        exit_sent = 1'b0;
        pend      = 1'b0;
        for (int c = 0; c < 150; c++) begin
            if (!pend) begin
                bus.wr_valid = 1'b0;
                k = (c < 80) ? int'($urandom_range(0, 4)) : (exit_sent ? int'($urandom_range(0, 4)) : 5);
                ch = 8'($urandom_range(32, 126));
                case (k)
                    0, 1: begin bus.wr_valid = 1'b1; bus.wr_addr = TH; bus.wr_data = {16'h0101, 40'($urandom), ch}; end
                    2: begin bus.wr_valid = 1'b1; bus.wr_addr = TH ^ (32'd1 << $urandom_range(2, 31));
                             bus.wr_data = {$urandom, $urandom} | 64'h1; end
                    3: begin bus.wr_valid = 1'b1; bus.wr_addr = TH; bus.wr_data = 64'h0; end
                    5: begin bus.wr_valid = 1'b1; bus.wr_addr = TH; bus.wr_data = 64'h1; exit_sent = 1'b1; end
                    default: bus.wr_valid = 1'b0;
                endcase
            end
            bus.con_ready = (c >= 80) ? 1'b1 : 1'($urandom_range(0, 1));
            #2;
            exp_rdy = exited || (exp_q.size() < DEPTH) || bus.con_ready;
            chk("rnd_wr_ready", bus.wr_ready, exp_rdy);
            chk("rnd_con_valid", bus.con_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("rnd_con_data", bus.con_data, exp_q[0]);
                chk("rnd_not_done", done, 0);
                if (bus.con_ready) void'(exp_q.pop_front());
            end
            acc = bus.wr_valid && exp_rdy;
            if (acc && !exited && bus.wr_addr == TH && bus.wr_data != 64'h0) begin
                if (bus.wr_data[63:48] == 16'h0101) exp_q.push_back(bus.wr_data[7:0]);
                else exited = 1'b1;
            end
            pend = bus.wr_valid && !acc;
            @(posedge clock);
            #1;
            if (exited && exp_q.size() == 0 && done) break;
        end
        bus.wr_valid = 1'b0;
        chk("rnd_done", done, 1);
        chk("rnd_pass", pass, 1);
        chk("rnd_exit_code", exit_code, 0);
        chk("rnd_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
